// File: rtl/au_inc_cnt.sv
// au_inc_cnt: loadable up-counter whose increment is formed by XORing the count
// with a shifted parallel-prefix AND of the count. ARCH selects the prefix network:
//   0 = ripple (serial chain), 1 = Sklansky, 2 = Kogge-Stone.
// Optional build macro AU_INC_CNT_SAT_EN: the counter saturates at all ones
// instead of wrapping, and co never asserts.
module au_inc_cnt #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned ARCH  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_val,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             co
);

   // Number of prefix levels for the log-depth networks.
   localparam int unsigned LVL = (WIDTH > 1) ? $clog2(WIDTH) : 0;

   logic [WIDTH-1:0] q_q, q_d;
   logic             co_q, co_d;
   logic [WIDTH-1:0] po;   // po[i] = &q_q[i:0]
   logic [WIDTH-1:0] inc;

   // Prefix-AND network over the current count.
   if (ARCH == 1 || ARCH == 2) begin : g_log
      for (genvar k = 0; k <= int'(LVL); k++) begin : g_lvl
         logic [WIDTH-1:0] p;
         if (k == 0) begin : g_base
            assign p = q_q;
         end else begin : g_step
            localparam int D = 2 ** (k - 1);
            for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
               if (ARCH == 2) begin : g_ks
                  // Kogge-Stone: combine with the node D positions below.
                  if (i >= D) begin : g_comb
                     assign p[i] = g_lvl[k-1].p[i] & g_lvl[k-1].p[i-D];
                  end else begin : g_pass
                     assign p[i] = g_lvl[k-1].p[i];
                  end
               end else begin : g_sk
                  // Sklansky: upper half of each 2D group takes the lower half's top node.
                  localparam int J = ((i >> (k - 1)) << (k - 1)) - 1;
                  if (((i >> (k - 1)) % 2) == 1) begin : g_comb
                     assign p[i] = g_lvl[k-1].p[i] & g_lvl[k-1].p[J];
                  end else begin : g_pass
                     assign p[i] = g_lvl[k-1].p[i];
                  end
               end
            end
         end
      end
      assign po = g_lvl[LVL].p;
   end else begin : g_rip
      for (genvar i = 0; i < int'(WIDTH); i++) begin : g_chain
         logic a;
         if (i == 0) begin : g_first
            assign a = q_q[0];
         end else begin : g_next
            assign a = g_chain[i-1].a & q_q[i];
         end
         assign po[i] = a;
      end
   end

   // Increment value: flip every bit whose lower bits are all ones.
   if (WIDTH == 1) begin : g_inc_w1
      assign inc = ~q_q;
   end else begin : g_inc_wn
      assign inc = q_q ^ {po[WIDTH-2:0], 1'b1};
   end

   // Terminal count is the top prefix node: all bits of q set.
   assign tc = po[WIDTH-1];

   // Next-state selection with priority clr > ld > en > hold (rst handled in the register).
   always_comb begin
      q_d  = q_q;
      co_d = 1'b0;
      if (clr) begin
         q_d = '0;
      end else if (ld) begin
         q_d = ld_val;
      end else if (en) begin
`ifdef AU_INC_CNT_SAT_EN
         if (!tc) begin
            q_d = inc;
         end
`else
         q_d  = inc;
         co_d = tc;
`endif
      end
   end

   // Count and carry-out registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q  <= '0;
         co_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         co_q <= co_d;
      end
   end

   assign q  = q_q;
   assign co = co_q;

endmodule

// File: tb/tb_au_inc_cnt.sv
// Bench for au_inc_cnt: three WIDTH=4 instances (ARCH 0..2) and one WIDTH=1
// instance share the control inputs; a scoreboard queue carries expected values.
module tb_au_inc_cnt;

   typedef struct packed {
      logic [3:0] q4;
      logic       co4;
      logic       q1;
      logic       co1;
   } exp_t;

   logic       clk;
   logic       rst, clr, ld, en;
   logic [3:0] ld_val;
   logic [0:0] ld_val1;

   logic [3:0] q4  [3];
   logic       tc4 [3];
   logic       co4 [3];
   logic [0:0] q1;
   logic       tc1, co1;

   exp_t sb[$];
   logic [3:0] m4;
   logic       m1;
   int         n_assert;
   int         n_fail;

   assign ld_val1 = ld_val[0:0];

   for (genvar a = 0; a < 3; a++) begin : g_dut
      au_inc_cnt #(.WIDTH(4), .ARCH(a)) u_dut (
         .clk    (clk),
         .rst    (rst),
         .clr    (clr),
         .ld     (ld),
         .ld_val (ld_val),
         .en     (en),
         .q      (q4[a]),
         .tc     (tc4[a]),
         .co     (co4[a])
      );
   end

   au_inc_cnt #(.WIDTH(1), .ARCH(0)) u_dut_w1 (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .ld     (ld),
      .ld_val (ld_val1),
      .en     (en),
      .q      (q1),
      .tc     (tc1),
      .co     (co1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pop one expected entry and compare every instance against it.
   task automatic compare();
      exp_t e;
      if (sb.size() == 0) begin
         n_assert++;
         n_fail++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
         return;
      end
      e = sb.pop_front();
      for (int a = 0; a < 3; a++) begin
         chk($sformatf("q_arch%0d", a),  q4[a],          e.q4);
         chk($sformatf("co_arch%0d", a), 4'(co4[a]),     4'(e.co4));
         chk($sformatf("tc_arch%0d", a), 4'(tc4[a]),     4'(e.q4 == 4'hF));
      end
      chk("q_w1",  4'(q1),  4'(e.q1));
      chk("co_w1", 4'(co1), 4'(e.co1));
      chk("tc_w1", 4'(tc1), 4'(e.q1));
   endtask

   // Drive one cycle of controls, predict the result, then check after the edge.
   task automatic step(input logic r, input logic c, input logic l,
                       input logic [3:0] v, input logic e);
      exp_t x;
      @(negedge clk);
      rst = r; clr = c; ld = l; ld_val = v; en = e;
      x.co4 = 1'b0;
      x.co1 = 1'b0;
      if (r || c) begin
         m4 = 4'h0;
         m1 = 1'b0;
      end else if (l) begin
         m4 = v;
         m1 = v[0];
      end else if (e) begin
`ifdef AU_INC_CNT_SAT_EN
         if (m4 != 4'hF) m4 = m4 + 4'h1;
         m1 = 1'b1;
`else
         x.co4 = (m4 == 4'hF);
         x.co1 = m1;
         m4 = m4 + 4'h1;
         m1 = ~m1;
`endif
      end
      x.q4 = m4;
      x.q1 = m1;
      sb.push_back(x);
      @(posedge clk);
      #1;
      compare();
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      m4 = 4'h0;
      m1 = 1'b0;
      rst = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0; ld_val = 4'h0;

      // Reset overrides a simultaneous load and enable.
      step(1'b1, 1'b0, 1'b1, 4'd9, 1'b1);

      // Count through a full wrap, then confirm co lasts one cycle.
      for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

      // Priority: clear beats load/enable at all ones, then load beats enable.
      step(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
      step(1'b0, 1'b1, 1'b1, 4'd5, 1'b1);
      step(1'b0, 1'b0, 1'b1, 4'd5, 1'b1);

      // Load at all ones with enable high must not pulse co.
      step(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
      step(1'b0, 1'b0, 1'b1, 4'd15, 1'b1);

      // Hold for three idle cycles.
      step(1'b0, 1'b0, 1'b1, 4'd7, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

      // Exhaustive single increments from every loaded value.
      for (int v = 0; v < 16; v++) begin
         step(1'b0, 1'b0, 1'b1, 4'(v), 1'b0);
         step(1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
      end

      // Reset during an enabled count at all ones.
      step(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
      step(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);

      // Random control mix.
      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/au_inc_cnt.md
AU_INC_CNT -- requirements
Module: AU_inc_cnt

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter word length (>= 1).
REQ-002 SHALL have parameter ARCH, default 0, prefix-AND architecture select (0 to 2), same encoding as the arithmetic-unit prefix blocks.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port clr, input, 1, synchronous clear of the count.
REQ-006 SHALL have port ld, input, 1, synchronous load strobe.
REQ-007 SHALL have port ld_val, input, WIDTH, value loaded when ld is high.
REQ-008 SHALL have port en, input, 1, count enable (increment by one).
REQ-009 SHALL have port q, output, WIDTH, registered count value.
REQ-010 SHALL have port tc, output, 1, terminal count, combinational, high when q is all ones.
REQ-011 SHALL have port co, output, 1, registered carry-out pulse marking a wrap from all ones to zero.

Function
REQ-012 SHALL compute the next increment value as q XOR {po[WIDTH-2:0], 1}, where po is the prefix AND of q built with the ARCH-selected parallel-prefix structure.
REQ-013 SHALL use next increment value ~q when WIDTH == 1.
REQ-014 SHALL apply per-cycle priority rst > clr > ld > en > hold.
REQ-015 SHALL set q to 0 and co to 0 on the cycle after clr is high and rst is low.
REQ-016 SHALL set q to ld_val and co to 0 on the cycle after ld is high and rst, clr are low; en is ignored that cycle.
REQ-017 SHALL set q to the increment value on the cycle after en is high and rst, clr, ld are low (latency 1 cycle).
REQ-018 SHALL hold q and drive co to 0 when rst, clr, ld and en are all low.
REQ-019 SHALL wrap q from all ones to 0 on an increment and assert co for exactly the following cycle.
REQ-020 SHALL assert co on every wrap when en is held high continuously, with no lost pulses.
REQ-021 SHALL assert tc in the same cycle q is all ones, independent of en, ld, clr.
REQ-022 SHALL not assert co when a load or clear overrides an enabled count at all ones.

Reset
REQ-023 SHALL drive q to 0 and co to 0 on the cycle after rst is high, regardless of clr, ld, en.
REQ-024 SHALL drive tc to 0 following reset when WIDTH >= 1 (q = 0).
REQ-025 SHALL abandon any operation requested in the same cycle as rst; no state survives reset.

Configuration
REQ-026 SHALL recognise the preprocessor macro AU_INC_CNT_SAT_EN.
REQ-027 SHALL, with AU_INC_CNT_SAT_EN defined, saturate: an increment at all ones holds q at all ones, and co stays 0 permanently.
REQ-028 SHALL, without AU_INC_CNT_SAT_EN, wrap per REQ-019 and REQ-020.
REQ-029 SHALL keep clr, ld, rst and tc behaviour identical in both configurations.

Verification (WIDTH=4, each ARCH 0..2)
REQ-030 SHALL cover reset: rst=1 with ld=1, ld_val=9, en=1 -> next cycle q=0, co=0, tc=0.
REQ-031 SHALL cover counting: en=1 for 16 cycles from q=0 -> q steps 1..15 then 0; tc=1 while q=15; co=1 only the cycle q returns to 0 (saturating build: q stays 15, co=0).
REQ-032 SHALL cover priority: q=15, clr=1, ld=1, ld_val=5, en=1 -> q=0, co=0; then ld=1, ld_val=5, en=1 -> q=5.
REQ-033 SHALL cover hold: q=7, all controls low for 3 cycles -> q=7, co=0, tc=0.
REQ-034 SHALL cover exhaustive increment: load every value 0..15 then one en cycle -> q=(v+1) mod 16 (saturating: min(v+1,15)); repeat with WIDTH=1 (0->1->0, co on wrap).
